// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: tracks HSYNC/VSYNC, checks line and frame timing,
// and reports lock, the active-video window and VRAM column/row of the current pixel.
module vga_sync_decoder #(
    parameter int H_SYNC_CLKS   = 384,
    parameter int H_BP_CLKS     = 192,
    parameter int H_ACT_CLKS    = 2560,
    parameter int H_TOTAL_CLKS  = 3200,
    parameter int H_TOL         = 4,
    parameter int V_SYNC_LINES  = 2,
    parameter int V_BP_LINES    = 33,
    parameter int V_ACT_LINES   = 480,
    parameter int V_TOTAL_LINES = 525,
    parameter int CLKS_PER_COL  = 20,
    parameter int LINES_PER_ROW = 5,
    parameter int LOCK_LINES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic        err_clr,
    output logic        LOCKED,
    output logic        VLOCKED,
    output logic [11:0] HCOUNT,
    output logic [9:0]  LINE,
    output logic        ACTIVE,
    output logic [6:0]  COL,
    output logic [6:0]  ROW,
    output logic        H_ERR,
    output logic        V_ERR
);

    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam int SW = $clog2(CLKS_PER_COL);
    localparam int RW = $clog2(LINES_PER_ROW);

    localparam logic [12:0] W_MIN = 13'(H_SYNC_CLKS - H_TOL);
    localparam logic [12:0] W_MAX = 13'(H_SYNC_CLKS + H_TOL);
    localparam logic [12:0] P_MIN = 13'(H_TOTAL_CLKS - H_TOL);
    localparam logic [12:0] P_MAX = 13'(H_TOTAL_CLKS + H_TOL);
    localparam logic [11:0] H_START = 12'(H_SYNC_CLKS + H_BP_CLKS);
    localparam logic [11:0] H_END   = 12'(H_SYNC_CLKS + H_BP_CLKS + H_ACT_CLKS - 1);
    localparam logic [9:0]  V_START = 10'(V_SYNC_LINES + V_BP_LINES);
    localparam logic [9:0]  V_END   = 10'(V_SYNC_LINES + V_BP_LINES + V_ACT_LINES - 1);
    localparam logic [10:0] F_NOM   = 11'(V_TOTAL_LINES);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_LINES - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(CLKS_PER_COL - 1);
    localparam logic [RW-1:0] RSUB_LAST = RW'(LINES_PER_ROW - 1);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_CHECK,
        S_LOCKED
    } state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   good_cnt, good_nx;
    logic            hs_r, vs_r;
    logic            hfall, hrise, vfall, hsat;
    logic [12:0]     cnt_p1;
    logic            w_ok, p_ok;
    logic            wok, wok_nx;
    logic            herr_set, locked_nx;

    logic [11:0]     hcount_nx;
    logic [9:0]      line_nx;
    logic [10:0]     frame_len;
    logic            pend, pend_nx, seen, seen_nx, consume;
    logic            vlock_nx, verr_set;
    logic            h_in, v_in, act_nx;
    logic [SW-1:0]   sub, sub_nx;
    logic [6:0]      col_cnt, col_nx;
    logic [RW-1:0]   rsub, rsub_nx;
    logic [6:0]      row_cnt, row_nx;

    assign hfall  = ~HSYNC & hs_r;
    assign hrise  = HSYNC & ~hs_r;
    assign vfall  = ~VSYNC & vs_r;
    assign hsat   = (HCOUNT == 12'hFFF);
    assign cnt_p1 = {1'b0, HCOUNT} + 13'd1;
    assign w_ok   = (cnt_p1 >= W_MIN) && (cnt_p1 <= W_MAX);
    assign p_ok   = (cnt_p1 >= P_MIN) && (cnt_p1 <= P_MAX);
    assign locked_nx = (state_nx == S_LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_SEARCH;
        else       state <= state_nx;
    end

    // wok remembers whether this line's sync width conformed, for the period check at hfall
    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        wok_nx   = wok;
        herr_set = 1'b0;
        if (hrise) wok_nx = w_ok;
        if (hfall) wok_nx = 1'b0;
        case (state)
            S_SEARCH: begin
                if (hfall) begin
                    state_nx = S_CHECK;
                    good_nx  = '0;
                end
            end
            S_CHECK: begin
                if (hfall) begin
                    if (wok && p_ok) begin
                        if (good_cnt == GOOD_LAST) begin
                            state_nx = S_LOCKED;
                            good_nx  = '0;
                        end else begin
                            good_nx = good_cnt + GW'(1);
                        end
                    end else begin
                        good_nx = '0;
                    end
                end else if (hsat) begin
                    good_nx = '0;
                end
            end
            S_LOCKED: begin
                if ((hrise && !w_ok) || (hfall && !p_ok) || hsat) begin
                    herr_set = 1'b1;
                    state_nx = S_CHECK;
                    good_nx  = '0;
                end
            end
            default: state_nx = S_SEARCH;
        endcase
    end

    always_comb begin
        hcount_nx = hfall ? 12'd0 : (hsat ? HCOUNT : HCOUNT + 12'd1);
        consume   = hfall & (pend | vfall);
        pend_nx   = consume ? 1'b0 : (pend | vfall);
        line_nx   = LINE;
        if (hfall) line_nx = consume ? 10'd0 : ((LINE == 10'h3FF) ? LINE : LINE + 10'd1);
        frame_len = {1'b0, LINE} + 11'd1;

        // the frame ending at the first consumed VSYNC after reset is partial, so skip it
        seen_nx  = seen;
        vlock_nx = VLOCKED;
        verr_set = 1'b0;
        if (consume) begin
            if (!seen) begin
                seen_nx = 1'b1;
            end else if (frame_len == F_NOM) begin
                vlock_nx = 1'b1;
            end else if (VLOCKED) begin
                verr_set = 1'b1;
                vlock_nx = 1'b0;
            end
        end
        vlock_nx = vlock_nx & locked_nx;

        h_in = (hcount_nx >= H_START) && (hcount_nx <= H_END);
        v_in = (line_nx >= V_START) && (line_nx <= V_END);

        sub_nx = '0;
        col_nx = '0;
        if (h_in && (hcount_nx != H_START)) begin
            if (sub == SUB_LAST) begin
                sub_nx = '0;
                col_nx = col_cnt + 7'd1;
            end else begin
                sub_nx = sub + SW'(1);
                col_nx = col_cnt;
            end
        end

        rsub_nx = rsub;
        row_nx  = row_cnt;
        if (hfall) begin
            rsub_nx = '0;
            row_nx  = '0;
            if (v_in && (line_nx != V_START)) begin
                if (rsub == RSUB_LAST) begin
                    row_nx = row_cnt + 7'd1;
                end else begin
                    rsub_nx = rsub + RW'(1);
                    row_nx  = row_cnt;
                end
            end
        end

        act_nx = locked_nx & vlock_nx & h_in & v_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_r     <= 1'b1;
            vs_r     <= 1'b1;
            good_cnt <= '0;
            wok      <= 1'b0;
            pend     <= 1'b0;
            seen     <= 1'b0;
            sub      <= '0;
            col_cnt  <= '0;
            rsub     <= '0;
            row_cnt  <= '0;
            HCOUNT   <= '0;
            LINE     <= '0;
            LOCKED   <= 1'b0;
            VLOCKED  <= 1'b0;
            ACTIVE   <= 1'b0;
            COL      <= '0;
            ROW      <= '0;
            H_ERR    <= 1'b0;
            V_ERR    <= 1'b0;
        end else begin
            hs_r     <= HSYNC;
            vs_r     <= VSYNC;
            good_cnt <= good_nx;
            wok      <= wok_nx;
            pend     <= pend_nx;
            seen     <= seen_nx;
            sub      <= sub_nx;
            col_cnt  <= col_nx;
            rsub     <= rsub_nx;
            row_cnt  <= row_nx;
            HCOUNT   <= hcount_nx;
            LINE     <= line_nx;
            LOCKED   <= locked_nx;
            VLOCKED  <= vlock_nx;
            ACTIVE   <= act_nx;
            COL      <= act_nx ? col_nx : 7'd0;
            ROW      <= act_nx ? row_nx : 7'd0;
            H_ERR    <= herr_set | (H_ERR & ~err_clr);
            V_ERR    <= verr_set | (V_ERR & ~err_clr);
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder with a cycle-stamped scoreboard; timing scaled down
// (short lines and frames) so several full frames fit in a short run.
module tb_vga_sync_decoder;

    localparam int HS   = 48;
    localparam int HBP  = 24;
    localparam int HACT = 320;
    localparam int HT   = 400;
    localparam int TOL  = 4;
    localparam int VS   = 2;
    localparam int VBP  = 2;
    localparam int VACT = 10;
    localparam int VT   = 16;
    localparam int CPC  = 20;
    localparam int LPR  = 5;

    localparam int H_START = HS + HBP;
    localparam int H_END   = HS + HBP + HACT - 1;
    localparam int V_START = VS + VBP;
    localparam int V_END   = VS + VBP + VACT - 1;
    localparam int NCOL    = HACT / CPC;

    logic        clk = 1'b0;
    logic        reset, HSYNC, VSYNC, err_clr;
    logic        LOCKED, VLOCKED, ACTIVE, H_ERR, V_ERR;
    logic [11:0] HCOUNT;
    logic [9:0]  LINE;
    logic [6:0]  COL, ROW;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_SYNC_CLKS(HS), .H_BP_CLKS(HBP), .H_ACT_CLKS(HACT), .H_TOTAL_CLKS(HT),
        .H_TOL(TOL), .V_SYNC_LINES(VS), .V_BP_LINES(VBP), .V_ACT_LINES(VACT),
        .V_TOTAL_LINES(VT), .CLKS_PER_COL(CPC), .LINES_PER_ROW(LPR), .LOCK_LINES(3)
    ) dut (
        .clk(clk), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC), .err_clr(err_clr),
        .LOCKED(LOCKED), .VLOCKED(VLOCKED), .HCOUNT(HCOUNT), .LINE(LINE),
        .ACTIVE(ACTIVE), .COL(COL), .ROW(ROW), .H_ERR(H_ERR), .V_ERR(V_ERR)
    );

    typedef enum int {O_LOCKED, O_VLOCKED, O_HCOUNT, O_LINE, O_ACTIVE,
                      O_COL, O_ROW, O_HERR, O_VERR} sig_e;

    typedef struct {
        string tag;
        sig_e  sig;
        int    exp;
        int    due;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic logic [31:0] observe(sig_e s);
        case (s)
            O_LOCKED:  return 32'(LOCKED);
            O_VLOCKED: return 32'(VLOCKED);
            O_HCOUNT:  return 32'(HCOUNT);
            O_LINE:    return 32'(LINE);
            O_ACTIVE:  return 32'(ACTIVE);
            O_COL:     return 32'(COL);
            O_ROW:     return 32'(ROW);
            O_HERR:    return 32'(H_ERR);
            O_VERR:    return 32'(V_ERR);
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input int exp);
        n_tests++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sched(input string tag, input sig_e s, input int exp, input int d);
        sb.push_back('{tag: tag, sig: s, exp: exp, due: cyc + d});
    endtask

    // One clock: drive inputs, take the edge, then retire every check due on this cycle
    task automatic tick(input bit hs, input bit vs, input bit clr);
        HSYNC   = hs;
        VSYNC   = vs;
        err_clr = clr;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                cmp(sb[i].tag, observe(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic hline(input int period, input int width, input int vs_at, input int clr_at);
        for (int i = 0; i < period; i++)
            tick(i >= width, !((vs_at >= 0) && (i >= vs_at)), i == clr_at);
    endtask

    task automatic all_zero(input string tag);
        for (int k = 0; k < 9; k++)
            cmp($sformatf("%s_out%0d", tag, k), observe(sig_e'(k)), 0);
    endtask

    initial begin
        reset = 1'b1; HSYNC = 1'b1; VSYNC = 1'b1; err_clr = 1'b0;
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        all_zero("reset");
        reset = 1'b0;

        // nominal lock: LOCKED the cycle after the 4th HSYNC fall
        sched("hcount_first", O_HCOUNT, 0, 1);
        sched("hcount_at_rise", O_HCOUNT, HS - 1, HS);
        sched("no_lock_search", O_LOCKED, 0, 1);
        repeat (3) hline(HT, HS, -1, -1);
        cmp("no_lock_3falls", LOCKED, 0);
        sched("lock_4th_fall", O_LOCKED, 1, 1);
        sched("herr_nominal", O_HERR, 0, 1);
        hline(HT, HS, -1, -1);

        // frame 1: simultaneous HSYNC/VSYNC fall, first frame never checked
        sched("line0_simul", O_LINE, 0, 1);
        hline(HT, HS, 0, -1);
        for (int l = 1; l < VT; l++) hline(HT, HS, -1, -1);
        cmp("vlock_first_frame", VLOCKED, 0);

        // frame 2: nominal length -> VLOCKED; active window / COL / ROW
        sched("vlock_2nd_vs", O_VLOCKED, 1, 1);
        for (int l = 0; l < VT; l++) begin
            if (l == V_START) begin
                sched("act_before", O_ACTIVE, 0, H_START);
                sched("act_start", O_ACTIVE, 1, H_START + 1);
                sched("col_start", O_COL, 0, H_START + 1);
                sched("row_start", O_ROW, 0, H_START + 1);
                sched("col0_last", O_COL, 0, H_START + CPC);
                sched("col1_first", O_COL, 1, H_START + CPC + 1);
                sched("col_penult", O_COL, NCOL - 2, H_END - CPC + 1);
                sched("col_last_first", O_COL, NCOL - 1, H_END - CPC + 2);
                sched("col_last_end", O_COL, NCOL - 1, H_END + 1);
                sched("act_end", O_ACTIVE, 1, H_END + 1);
                sched("act_after", O_ACTIVE, 0, H_END + 2);
                sched("col_after", O_COL, 0, H_END + 2);
            end
            if (l == V_START + LPR) begin
                sched("row1", O_ROW, 1, H_START + 1);
                sched("act_row1", O_ACTIVE, 1, H_START + 1);
            end
            if (l == V_END) sched("row_last", O_ROW, (VACT - 1) / LPR, H_END + 1);
            if (l == V_START - 1) sched("act_vbp", O_ACTIVE, 0, H_START + 10);
            if (l == V_END + 1) sched("act_vfp", O_ACTIVE, 0, H_START + 10);
            hline(HT, HS, (l == 0) ? 0 : ((l == VT - 1) ? 200 : -1), -1);
        end

        // frame 3: VSYNC fell mid-line, consumed at the next HSYNC fall; one line short
        sched("line0_pend", O_LINE, 0, 1);
        sched("vlock_keep", O_VLOCKED, 1, 1);
        for (int l = 0; l < VT - 1; l++) hline(HT, HS, -1, -1);
        cmp("line_short", LINE, VT - 2);

        // frame 4 start: short frame flagged
        sched("verr_short", O_VERR, 1, 1);
        sched("vlock_drop", O_VLOCKED, 0, 1);
        sched("line0_f4", O_LINE, 0, 1);
        sched("lock_keep_f4", O_LOCKED, 1, 1);
        for (int l = 0; l < 6; l++) begin
            if (l == 1) begin
                sched("verr_held", O_VERR, 1, 10);
                sched("verr_clr", O_VERR, 0, 11);
            end
            if (l == 5) sched("act_nov", O_ACTIVE, 0, H_START + 10);
            hline(HT, HS, (l == 0) ? 0 : -1, (l == 1) ? 10 : -1);
        end

        // period tolerance: +4 holds lock, +5 breaks it
        hline(HT + TOL, HS, -1, -1);
        sched("lock_p_tol", O_LOCKED, 1, 1);
        sched("herr_p_tol", O_HERR, 0, 1);
        hline(HT + TOL + 1, HS, -1, -1);
        sched("lock_p_bad", O_LOCKED, 0, 1);
        sched("herr_p_bad", O_HERR, 1, 1);
        repeat (3) hline(HT, HS, -1, -1);
        cmp("no_relock_early", LOCKED, 0);
        cmp("herr_sticky", H_ERR, 1);
        sched("relock", O_LOCKED, 1, 1);
        sched("herr_before_clr", O_HERR, 1, 100);
        sched("herr_after_clr", O_HERR, 0, 101);
        hline(HT, HS, -1, 100);

        // width tolerance: -4 holds lock, -5 breaks it at the HSYNC rise
        sched("lock_w_tol", O_LOCKED, 1, HS + 2);
        sched("herr_w_tol", O_HERR, 0, HS + 2);
        hline(HT, HS - TOL, -1, -1);
        sched("lock_w_pre", O_LOCKED, 1, HS - TOL - 1);
        sched("lock_w_bad", O_LOCKED, 0, HS - TOL);
        sched("herr_w_bad", O_HERR, 1, HS - TOL);
        hline(HT, HS - TOL - 1, -1, -1);

        // relock (clearing H_ERR), then an over-long line saturates HCOUNT
        sched("herr_clr2", O_HERR, 0, 11);
        hline(HT, HS, -1, 10);
        repeat (2) hline(HT, HS, -1, -1);
        sched("lock_long", O_LOCKED, 1, 1);
        sched("lock_pre_sat", O_LOCKED, 1, 4096);
        sched("hcount_sat", O_HCOUNT, 4095, 4096);
        sched("lock_sat", O_LOCKED, 0, 4097);
        sched("herr_sat", O_HERR, 1, 4097);
        sched("hcount_hold", O_HCOUNT, 4095, 4200);
        hline(4200, HS, -1, -1);

        // relock, then asynchronous reset mid-line
        repeat (3) hline(HT, HS, -1, -1);
        for (int i = 0; i <= 1000; i++) tick(i >= HS, 1'b1, 1'b0);
        cmp("hcount_1000", HCOUNT, 1000);
        cmp("lock_1000", LOCKED, 1);
        #2 reset = 1'b1;
        #1 all_zero("async_reset");
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        repeat (3) hline(HT, HS, -1, -1);
        cmp("no_lock_post_rst", LOCKED, 0);
        sched("lock_post_rst", O_LOCKED, 1, 1);
        hline(HT, HS, -1, -1);

        foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: check never reached, expected %0d", sb[i].tag, sb[i].exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
